// File: rtl/lcd_hd44780_driver_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the HD44780 character LCD writer: command codes,
// the init-sequence length, the controller state type and a helper that maps
// an init index to its command byte.
// Configuration macro: LCD_CURSOR_BLINK_EN selects the display-on command
// used as the fourth init command (0x0F when defined, 0x0C otherwise).
// -----------------------------------------------------------------------------
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_SET   = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISP_ON    = 8'h0C;  // display on, cursor/blink off
  localparam logic [7:0] CMD_DISP_BLINK = 8'h0F;  // display on, cursor and blink on
  localparam logic [7:0] CMD_CLEAR      = 8'h01;  // clear display, home cursor
  localparam logic [7:0] CMD_ENTRY      = 8'h06;  // increment address, no shift
  localparam logic [7:0] CMD_LINE2      = 8'hC0;  // set DDRAM address 0x40

  localparam int INIT_LEN = 6;

`ifdef LCD_CURSOR_BLINK_EN
  localparam logic [7:0] CMD_DISPLAY = CMD_DISP_BLINK;
`else
  localparam logic [7:0] CMD_DISPLAY = CMD_DISP_ON;
`endif

  typedef enum logic [3:0] {
    PWRUP      = 4'd0,
    INIT_SETUP = 4'd1,
    INIT_PULSE = 4'd2,
    INIT_HOLD  = 4'd3,
    INIT_WAIT  = 4'd4,
    IDLE       = 4'd5,
    SETUP      = 4'd6,
    PULSE      = 4'd7,
    HOLD       = 4'd8,
    WAIT       = 4'd9,
    DONE       = 4'd10
  } lcd_state_t;

  // Command byte issued at position idx of the power-up init sequence.
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    logic [7:0] cmd_s;
    case (idx)
      3'd0, 3'd1, 3'd2: cmd_s = CMD_FUNC_SET;
      3'd3:             cmd_s = CMD_DISPLAY;
      3'd4:             cmd_s = CMD_CLEAR;
      3'd5:             cmd_s = CMD_ENTRY;
      default:          cmd_s = CMD_ENTRY;
    endcase
    return cmd_s;
  endfunction

endpackage

// File: rtl/lcd_hd44780_driver_if.sv
// -----------------------------------------------------------------------------
// lcd_hd44780_driver_if
// Handshake between the message sequencer (master) and the LCD writer (slave).
//   DatoLCD      : character code offered by the sequencer
//   Lista        : level, DatoLCD holds a valid character
//   Linea2       : level, move the cursor to line 2
//   Cuenta       : one-cycle acknowledge per completed write
//   Inicializada : display init sequence finished
// -----------------------------------------------------------------------------
interface lcd_hd44780_driver_if;
  logic [7:0] DatoLCD;
  logic       Lista;
  logic       Linea2;
  logic       Cuenta;
  logic       Inicializada;

  modport master (output DatoLCD, Lista, Linea2, input Cuenta, Inicializada);
  modport slave  (input DatoLCD, Lista, Linea2, output Cuenta, Inicializada);
endinterface

// File: rtl/lcd_hd44780_driver_timer.sv
// -----------------------------------------------------------------------------
// lcd_delay_timer
// Single down-counter shared by every timed phase of the LCD writer.
//   Clk   : system clock, rising edge
//   Reset : synchronous active-high reset
//   start : load a new delay this cycle
//   load  : delay length in cycles (0 behaves like 1)
//   done  : registered; high from the last cycle of the delay until next start
// A delay of N loaded at edge t makes done visible during the N-th cycle
// after t, so a phase lasting N cycles leaves on the edge where done is seen.
// -----------------------------------------------------------------------------
module lcd_delay_timer #(
  parameter int W = 24
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         start,
  input  logic [W-1:0] load,
  output logic         done
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count_r;
  logic         done_r;

  // Count down from the loaded value and flag the final cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_r <= '0;
      done_r  <= 1'b0;
    end else if (start) begin
      if (load <= ONE) begin
        count_r <= '0;
        done_r  <= 1'b1;
      end else begin
        count_r <= load - ONE;
        done_r  <= 1'b0;
      end
    end else if (count_r != '0) begin
      count_r <= count_r - ONE;
      done_r  <= (count_r == ONE);
    end else begin
      done_r  <= done_r;
    end
  end

  assign done = done_r;

endmodule

// File: rtl/lcd_hd44780_driver.sv
// -----------------------------------------------------------------------------
// lcd_hd44780_driver
// Physical-side writer for a 16x2 HD44780 LCD in 8-bit mode. Runs the power-up
// init sequence, then writes one character (or the line-2 command) per
// sequencer request and acknowledges each completed write with Cuenta.
//   Clk, Reset : clock and synchronous active-high reset
//   seq        : sequencer handshake (DatoLCD/Lista/Linea2/Cuenta/Inicializada)
//   LCD_RS     : 0 = command, 1 = data
//   LCD_RW     : always 0 (write only)
//   LCD_E      : enable strobe
//   LCD_DB     : data bus
// Configuration macro: LCD_CURSOR_BLINK_EN (see lcd_pkg) turns on the cursor
// and blink in the display-on init command; timing is unchanged.
// -----------------------------------------------------------------------------
module lcd_hd44780_driver
  import lcd_pkg::*;
#(
  parameter int PWRUP_CYC      = 750000,
  parameter int E_PULSE_CYC    = 12,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 82000
) (
  input  logic                 Clk,
  input  logic                 Reset,
  lcd_hd44780_driver_if.slave  seq,
  output logic                 LCD_RS,
  output logic                 LCD_RW,
  output logic                 LCD_E,
  output logic [7:0]           LCD_DB
);

  localparam logic [23:0] PWRUP_L = 24'(PWRUP_CYC);
  localparam logic [23:0] E_L     = 24'(E_PULSE_CYC);
  localparam logic [23:0] CMD_L   = 24'(CMD_WAIT_CYC);
  localparam logic [23:0] CLEAR_L = 24'(CLEAR_WAIT_CYC);
  localparam logic [2:0]  IDX_LAST = 3'(INIT_LEN - 1);

  lcd_state_t  state_r, state_s;
  logic [2:0]  idx_r, idx_s;
  logic [7:0]  db_r, db_s;
  logic        rs_r, rs_s;
  logic        armed_r, armed_s;   // power-up delay already loaded
  logic        hold_r, hold_s;     // skip sampling for one IDLE cycle after DONE
  logic        e_r, rw_r, cuenta_r, init_r;
  logic        tmr_start_s;
  logic [23:0] tmr_load_s;
  logic        tmr_done_s;

  lcd_delay_timer #(.W(24)) u_timer (
    .Clk   (Clk),
    .Reset (Reset),
    .start (tmr_start_s),
    .load  (tmr_load_s),
    .done  (tmr_done_s)
  );

  // Next-state logic; DB/RS are latched only when a write is accepted.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    db_s        = db_r;
    rs_s        = rs_r;
    armed_s     = armed_r;
    hold_s      = hold_r;
    tmr_start_s = 1'b0;
    tmr_load_s  = 24'd0;
    case (state_r)
      PWRUP: begin
        if (!armed_r) begin
          armed_s     = 1'b1;
          tmr_start_s = 1'b1;
          tmr_load_s  = PWRUP_L;
        end else if (tmr_done_s) begin
          state_s = INIT_SETUP;
          idx_s   = 3'd0;
          db_s    = init_cmd(3'd0);
          rs_s    = 1'b0;
        end else begin
          state_s = PWRUP;
        end
      end
      INIT_SETUP: begin
        state_s     = INIT_PULSE;
        tmr_start_s = 1'b1;
        tmr_load_s  = E_L;
      end
      INIT_PULSE: begin
        if (tmr_done_s) begin
          state_s     = INIT_HOLD;
          tmr_start_s = 1'b1;
          tmr_load_s  = E_L;
        end else begin
          state_s = INIT_PULSE;
        end
      end
      INIT_HOLD: begin
        if (tmr_done_s) begin
          state_s     = INIT_WAIT;
          tmr_start_s = 1'b1;
          tmr_load_s  = (db_r == CMD_CLEAR) ? CLEAR_L : CMD_L;
        end else begin
          state_s = INIT_HOLD;
        end
      end
      INIT_WAIT: begin
        if (!tmr_done_s) begin
          state_s = INIT_WAIT;
        end else if (idx_r == IDX_LAST) begin
          state_s = IDLE;
        end else begin
          state_s = INIT_SETUP;
          idx_s   = idx_r + 3'd1;
          db_s    = init_cmd(idx_r + 3'd1);
          rs_s    = 1'b0;
        end
      end
      IDLE: begin
        if (hold_r) begin
          hold_s = 1'b0;
        end else if (seq.Linea2) begin
          state_s = SETUP;
          db_s    = CMD_LINE2;
          rs_s    = 1'b0;
        end else if (seq.Lista) begin
          state_s = SETUP;
          db_s    = seq.DatoLCD;
          rs_s    = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        state_s     = PULSE;
        tmr_start_s = 1'b1;
        tmr_load_s  = E_L;
      end
      PULSE: begin
        if (tmr_done_s) begin
          state_s     = HOLD;
          tmr_start_s = 1'b1;
          tmr_load_s  = E_L;
        end else begin
          state_s = PULSE;
        end
      end
      HOLD: begin
        if (tmr_done_s) begin
          state_s     = WAIT;
          tmr_start_s = 1'b1;
          tmr_load_s  = CMD_L;
        end else begin
          state_s = HOLD;
        end
      end
      WAIT: begin
        if (tmr_done_s) begin
          state_s = DONE;
        end else begin
          state_s = WAIT;
        end
      end
      DONE: begin
        state_s = IDLE;
        hold_s  = 1'b1;
      end
      default: begin
        state_s = PWRUP;
        armed_s = 1'b0;
      end
    endcase
  end

  // State and output registers; outputs are decoded from the next state so
  // they line up with the state they belong to.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r  <= PWRUP;
      idx_r    <= 3'd0;
      db_r     <= 8'h00;
      rs_r     <= 1'b0;
      armed_r  <= 1'b0;
      hold_r   <= 1'b0;
      e_r      <= 1'b0;
      rw_r     <= 1'b0;
      cuenta_r <= 1'b0;
      init_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      idx_r    <= idx_s;
      db_r     <= db_s;
      rs_r     <= rs_s;
      armed_r  <= armed_s;
      hold_r   <= hold_s;
      e_r      <= (state_s == INIT_PULSE) || (state_s == PULSE);
      rw_r     <= 1'b0;
      cuenta_r <= (state_s == DONE);
      init_r   <= init_r || (state_s == IDLE);
    end
  end

  assign LCD_RS           = rs_r;
  assign LCD_RW           = rw_r;
  assign LCD_E            = e_r;
  assign LCD_DB           = db_r;
  assign seq.Cuenta       = cuenta_r;
  assign seq.Inicializada = init_r;

endmodule

// File: doc/lcd_hd44780_driver.md
Name: lcd_hd44780_driver

Overview:
Physical-side writer for a 16x2 HD44780-compatible character LCD in 8-bit mode. It consumes the character stream from the message sequencer (DatoLCD/Lista/Linea2) and returns a one-cycle Cuenta acknowledge per completed write, so the sequencer advances exactly one character at a time. It runs the power-up init sequence, generates E strobes with setup/hold/settle timing, and flags when the display is ready.

Parameters:
PWRUP_CYC, 750000, power-up wait before first command (15 ms at 50 MHz)
E_PULSE_CYC, 12, E high width and post-E hold width (240 ns at 50 MHz)
CMD_WAIT_CYC, 2000, settle time after a normal command or data write (40 us)
CLEAR_WAIT_CYC, 82000, settle time after the clear command (1.64 ms)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
DatoLCD  in  8  character code from the sequencer
Lista  in  1  level: DatoLCD holds a valid character to write
Linea2  in  1  level: move cursor to line 2 (DDRAM 0x40)
Cuenta  out  1  one-cycle pulse: current request completed
Inicializada  out  1  high once the init sequence is finished
LCD_RS  out  1  0 = command, 1 = data
LCD_RW  out  1  tied 0 (write only)
LCD_E  out  1  enable strobe
LCD_DB  out  8  LCD data bus

Behaviour:
- All outputs are registered. On Reset: LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_DB=0x00, Cuenta=0, Inicializada=0, FSM=PWRUP, timer=0.
- Reset mid-operation, including during an E pulse, forces E low on the next edge and restarts from PWRUP. No Cuenta is issued for the aborted request.
- Timer: one down-counter, 24 bits wide. All parameters must be below 2^24.
- PWRUP: wait PWRUP_CYC cycles.
- INIT: issue commands in order 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06, all with RS=0. Each uses the write cycle below. The wait after 0x01 is CLEAR_WAIT_CYC; all others use CMD_WAIT_CYC. Cuenta is never pulsed during INIT.
- Inicializada rises on entry to IDLE after the final init wait and stays high until Reset.
- IDLE: sample requests only here. Priority:
  - Linea2=1: latch command 0xC0, RS=0.
  - else Lista=1: latch DatoLCD, RS=1.
  - else stay in IDLE.
- Requests raised before Inicializada are ignored while held. Because they are levels, they are served once IDLE is reached.
- Write cycle, with IDLE acceptance as cycle 0:
  - SETUP: cycle 1, RS/DB driven, E=0.
  - PULSE: E_PULSE_CYC cycles, E=1.
  - HOLD: E_PULSE_CYC cycles, E=0, RS/DB held.
  - WAIT: CMD_WAIT_CYC cycles.
  - DONE: Cuenta=1 for exactly one cycle, at cycle 2+2*E_PULSE_CYC+CMD_WAIT_CYC, then return to IDLE.
- IDLE always lasts at least one cycle after DONE, so the sequencer's state update is seen before re-sampling. No double write of one character.
- DB/RS come from latched values. Changes on DatoLCD/Lista/Linea2 during a write cycle have no effect.
- Lista and Linea2 both 0 (sequencer Inicio/Fin): remain in IDLE with E=0 and DB holding its last value.
- States: PWRUP, INIT_SETUP, INIT_PULSE, INIT_HOLD, INIT_WAIT, IDLE, SETUP, PULSE, HOLD, WAIT, DONE. The init index (0..5) is a separate 3-bit counter.

Optional Feature:
LCD_CURSOR_BLINK_EN:
- Defined: the fourth init command is 0x0F (display on, cursor on, blink on).
- Undefined: it is 0x0C (display on, cursor and blink off).
- Timing is identical either way.

Decomposition:
- Package lcd_pkg holds:
  - CMD_FUNC_SET=0x38, CMD_DISP_ON=0x0C, CMD_DISP_BLINK=0x0F, CMD_CLEAR=0x01, CMD_ENTRY=0x06, CMD_LINE2=0xC0
  - the FSM state typedef
  - INIT_LEN=6
- Sub-module lcd_delay_timer: load value plus start input, produces a registered done flag. It is shared by the init and write paths.

Test Plan:
(Bench params: PWRUP_CYC=20, E_PULSE_CYC=2, CMD_WAIT_CYC=5, CLEAR_WAIT_CYC=10.)
1. Reset, then idle inputs -> no E for 20 cycles; E pulses carry DB=38,38,38,0C,01,06 with RS=0, each E high exactly 2 cycles; gap after 01 is ≥10 cycles; Inicializada=1 after the last wait; Cuenta stays 0 throughout.
2. After init, Lista=1, DatoLCD=0x50 -> RS=1, DB=0x50, E high cycles 2-3; exactly one Cuenta pulse at cycle 11; next acceptance no earlier than cycle 13.
3. Linea2=1 and Lista=1 together -> DB=0xC0, RS=0 written first; one Cuenta pulse.
4. Lista=1 asserted from reset -> no RS=1 strobe before Inicializada; character written immediately after.
5. Reset pulsed while E=1 -> E=0 the next cycle; Inicializada=0; full init replays; no Cuenta.
6. DatoLCD changed 0x50->0x41 during PULSE -> DB stays 0x50 until DONE.
